noc_flit_tx: RTL and testbench

Packet-to-flit transmitter for the network interface injection port. Accepts a packet request (destination, virtual channel, length) and a stream of 32-bit payload words. Segments them into one head flit, zero or more body flits and one tail flit. Drives them over the 34-bit valid/ready flit interface into a router input VC buffer. The receiving buffer locks its VC on a head flit with a non-zero destination and unlocks it on the tail; this block produces exactly that framing.

---
 rtl/noc_flit_tx.sv | 145 ++++++++++++++
 tb/tb_noc_flit_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_tx.sv
// rtl/noc_flit_tx.sv - packet-to-flit transmitter: head/body/tail framing over a 34-bit valid/ready link
// Optional destination check: define NOC_FLIT_TX_DEST_CHECK_EN to drop requests addressed to 0/0.
module noc_flit_tx #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_x_i,
    input  logic [3:0]       req_y_i,
    input  logic [1:0]       req_vc_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [31:0]      data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [33:0]      fdata_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [1:0]       vc_id_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       vc_q, vc_d;
    logic [33:0]      fdata_q, fdata_d;
    logic             valid_q, valid_d;

    logic             slot_free;
    logic [LEN_W-1:0] eff_len;
    logic [7:0]       len_field;
    logic [33:0]      head_flit;

    assign slot_free = !valid_q || ready_i;
    assign eff_len   = (req_len_i == '0) ? LEN_W'(1) : req_len_i;
    assign len_field = 8'(eff_len);
    assign head_flit = {T_HEAD, 2'b00, req_x_i, req_y_i, len_field, 14'd0};

`ifdef NOC_FLIT_TX_DEST_CHECK_EN
    logic err_q, err_d;
`endif

    // rem counts body flits still to send; the last body hands over to TAIL
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        vc_d         = vc_q;
        fdata_d      = fdata_q;
        valid_d      = valid_q && !ready_i;
        req_ready_o  = 1'b0;
        data_ready_o = 1'b0;
`ifdef NOC_FLIT_TX_DEST_CHECK_EN
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_o = slot_free;
                if (req_valid_i && slot_free) begin
`ifdef NOC_FLIT_TX_DEST_CHECK_EN
                    if (req_x_i == 4'd0 && req_y_i == 4'd0) begin
                        err_d = 1'b1;
                    end else
`endif
                    begin
                        fdata_d = head_flit;
                        valid_d = 1'b1;
                        vc_d    = req_vc_i;
                        rem_d   = eff_len - LEN_W'(1);
                        state_d = (eff_len > LEN_W'(1)) ? S_BODY : S_TAIL;
                    end
                end
            end
            S_BODY: begin
                data_ready_o = slot_free;
                if (data_valid_i && slot_free) begin
                    fdata_d = {T_BODY, data_i};
                    valid_d = 1'b1;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                data_ready_o = slot_free;
                if (data_valid_i && slot_free) begin
                    fdata_d = {T_TAIL, data_i};
                    valid_d = 1'b1;
                    rem_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            vc_q    <= 2'd0;
            fdata_q <= 34'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            vc_q    <= vc_d;
            fdata_q <= fdata_d;
            valid_q <= valid_d;
        end
    end

`ifdef NOC_FLIT_TX_DEST_CHECK_EN
    always_ff @(posedge clk) begin
        if (arst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign fdata_o = fdata_q;
    assign valid_o = valid_q;
    assign vc_id_o = vc_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_noc_flit_tx.sv
// tb/tb_noc_flit_tx.sv - scoreboard bench for noc_flit_tx with randomized packets and backpressure
module tb_noc_flit_tx;

    logic        clk = 1'b0;
    logic        arst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_x_i;
    logic [3:0]  req_y_i;
    logic [1:0]  req_vc_i;
    logic [7:0]  req_len_i;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [33:0] fdata_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  vc_id_o;
    logic        busy_o;
    logic        err_o;

    noc_flit_tx #(.LEN_W(8)) dut (
        .clk          (clk),
        .arst         (arst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_x_i      (req_x_i),
        .req_y_i      (req_y_i),
        .req_vc_i     (req_vc_i),
        .req_len_i    (req_len_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .fdata_o      (fdata_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .vc_id_o      (vc_id_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] vc;
        logic [7:0] len;
        int         nw;
    } desc_t;

    typedef struct {
        logic [33:0] f;
        logic [1:0]  vc;
    } exp_t;

    desc_t       pkt_q[$];
    logic [31:0] word_q[$];
    exp_t        exp_q[$];
    int          xfer_cyc[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit rand_ready = 1'b0;
    bit drv_busy = 1'b0;
    int gap_pct = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: flit list derived from the packet description alone
    task automatic queue_pkt(input logic [3:0] x, input logic [3:0] y, input logic [1:0] vc,
                             input logic [7:0] len, input logic [31:0] w0);
        desc_t d;
        exp_t e;
        int L;
        int hv;
        logic [31:0] w;
        L = (len == 8'd0) ? 1 : int'(len);
        d.x = x; d.y = y; d.vc = vc; d.len = len; d.nw = L;
`ifdef NOC_FLIT_TX_DEST_CHECK_EN
        if (x == 4'd0 && y == 4'd0) d.nw = 0;
`endif
        if (d.nw > 0) begin
            hv = (int'(x) << 26) + (int'(y) << 22) + ((L % 256) << 14);
            e.vc = vc;
            e.f = {2'b00, 32'(hv)};
            exp_q.push_back(e);
            for (int i = 0; i < L; i++) begin
                w = (i == 0) ? w0 : $urandom;
                word_q.push_back(w);
                e.f = {((i == L - 1) ? 2'b11 : 2'b01), w};
                exp_q.push_back(e);
            end
        end
        pkt_q.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((pkt_q.size() != 0 || drv_busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= budget), 64'd0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) ready_i = ($urandom % 4) != 0;
    end

    always @(negedge clk) begin
        if (mon_en && !arst && valid_o && ready_i) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("flit_without_expectation", 64'(fdata_o), 64'h3_0000_0000_0000);
            end else begin
                mon_e = exp_q.pop_front();
                chk("flit_data", 64'(fdata_o), 64'(mon_e.f));
                chk("flit_vc", 64'(vc_id_o), 64'(mon_e.vc));
            end
        end
    end

    initial begin
        desc_t d;
        int to;
        forever begin
            @(posedge clk); #1;
            while (pkt_q.size() > 0) begin
                drv_busy = 1'b1;
                d = pkt_q.pop_front();
                req_x_i = d.x; req_y_i = d.y; req_vc_i = d.vc; req_len_i = d.len;
                req_valid_i = 1'b1;
                to = 0;
                @(negedge clk);
                while (!req_ready_o && to < 1000) begin @(negedge clk); to++; end
                if (to >= 1000) chk("req_accept_timeout", 64'd1, 64'd0);
                @(posedge clk); #1;
                req_valid_i = 1'b0;
                for (int i = 0; i < d.nw; i++) begin
                    if (gap_pct > 0 && int'($urandom % 100) < gap_pct) begin
                        data_valid_i = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    data_i = word_q.pop_front();
                    data_valid_i = 1'b1;
                    to = 0;
                    @(negedge clk);
                    while (!data_ready_o && to < 1000) begin @(negedge clk); to++; end
                    if (to >= 1000) chk("data_accept_timeout", 64'd1, 64'd0);
                    @(posedge clk); #1;
                end
                data_valid_i = 1'b0;
            end
            drv_busy = 1'b0;
        end
    end

    initial begin
        int to;
        arst = 1'b1; req_valid_i = 1'b0; req_x_i = '0; req_y_i = '0; req_vc_i = '0;
        req_len_i = '0; data_i = '0; data_valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_fdata", 64'(fdata_o), 64'd0);
        chk("rst_vc", 64'(vc_id_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_data_ready", 64'(data_ready_o), 64'd0);
        mon_en = 1'b1;

        // single-word packet: head and tail on consecutive cycles
        @(posedge clk); #1;
        xfer_cyc.delete();
        queue_pkt(4'd3, 4'd5, 2'd2, 8'd1, 32'hDEADBEEF);
        wait_drain(200);
        chk("single_flit_count", 64'(xfer_cyc.size()), 64'd2);
        if (xfer_cyc.size() == 2) chk("single_back_to_back", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
        @(negedge clk);
        chk("single_busy_after", 64'(busy_o), 64'd0);
        @(posedge clk); #1;

        // four words, continuous
        xfer_cyc.delete();
        queue_pkt(4'd1, 4'd2, 2'd1, 8'd4, $urandom);
        wait_drain(200);
        chk("four_flit_count", 64'(xfer_cyc.size()), 64'd5);
        if (xfer_cyc.size() == 5) chk("four_back_to_back", 64'(xfer_cyc[4] - xfer_cyc[0]), 64'd4);

        // backpressure on a body flit
        queue_pkt(4'd6, 4'd7, 2'd3, 8'd4, $urandom);
        to = 0;
        do begin @(posedge clk); #1; to++; end
        while (!(valid_o && fdata_o[33:32] == 2'b01) && to < 100);
        chk("bp_body_seen_timeout", 64'(to >= 100), 64'd0);
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_data_ready", 64'(data_ready_o), 64'd0);
            chk("bp_req_ready", 64'(req_ready_o), 64'd0);
            if (exp_q.size() > 0) begin
                chk("bp_fdata_held", 64'(fdata_o), 64'(exp_q[0].f));
                chk("bp_vc_held", 64'(vc_id_o), 64'(exp_q[0].vc));
            end
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        wait_drain(200);

        // back-to-back len=2 packets
        xfer_cyc.delete();
        queue_pkt(4'd2, 4'd3, 2'd0, 8'd2, $urandom);
        queue_pkt(4'd4, 4'd1, 2'd3, 8'd2, $urandom);
        wait_drain(200);
        chk("b2b_flit_count", 64'(xfer_cyc.size()), 64'd6);
        if (xfer_cyc.size() == 6) chk("b2b_no_bubble", 64'(xfer_cyc[5] - xfer_cyc[0]), 64'd5);

        // len=0 behaves as len=1
        xfer_cyc.delete();
        queue_pkt(4'd7, 4'd9, 2'd1, 8'd0, $urandom);
        wait_drain(200);
        chk("len0_flit_count", 64'(xfer_cyc.size()), 64'd2);

        // reset while in BODY
        mon_en = 1'b0;
        req_x_i = 4'd1; req_y_i = 4'd2; req_vc_i = 2'd1; req_len_i = 8'd4; req_valid_i = 1'b1;
        @(negedge clk);
        chk("rstmid_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; data_i = 32'h1234_5678; data_valid_i = 1'b1;
        @(negedge clk);
        chk("rstmid_head_valid", 64'(valid_o), 64'd1);
        chk("rstmid_busy", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0; data_valid_i = 1'b0;
        @(negedge clk);
        chk("rstmid_valid_cleared", 64'(valid_o), 64'd0);
        chk("rstmid_busy_cleared", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // destination 0/0
`ifdef NOC_FLIT_TX_DEST_CHECK_EN
        req_x_i = 4'd0; req_y_i = 4'd0; req_vc_i = 2'd3; req_len_i = 8'd2; req_valid_i = 1'b1;
        @(negedge clk);
        chk("dest0_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("dest0_err_pulse", 64'(err_o), 64'd1);
        chk("dest0_no_flit", 64'(valid_o), 64'd0);
        chk("dest0_idle", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("dest0_err_single", 64'(err_o), 64'd0);
        @(posedge clk); #1;
`else
        xfer_cyc.delete();
        queue_pkt(4'd0, 4'd0, 2'd3, 8'd2, $urandom);
        @(negedge clk);
        @(negedge clk);
        chk("dest0_err_low", 64'(err_o), 64'd0);
        wait_drain(200);
        chk("dest0_flit_count", 64'(xfer_cyc.size()), 64'd3);
`endif

        // randomized traffic with random backpressure and data gaps
        rand_ready = 1'b1;
        gap_pct = 30;
        for (int p = 0; p < 40; p++) begin
            logic [3:0] rx, ry;
            logic [7:0] rl;
            rx = 4'($urandom); ry = 4'($urandom);
            if ($urandom % 8 == 0) begin rx = 4'd0; ry = 4'd0; end
            rl = 8'($urandom_range(0, 6));
            if (p == 17) rl = 8'd20;
            queue_pkt(rx, ry, 2'($urandom), rl, $urandom);
        end
        wait_drain(20000);
        rand_ready = 1'b0;
        ready_i = 1'b1;
        gap_pct = 0;
        @(negedge clk);
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
